// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC vectoring core.
// The COMP state is only present when GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int          INT_W       = 20;
  localparam logic [15:0] K_INV       = 16'h26DD;
  localparam int          K_INV_FRAC  = 14;
  localparam logic [15:0] HALF_PI_Q14 = 16'h6488;

`ifdef GAIN_COMP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/cordic_gain_mult.sv
// 1/K gain compensation: mag = (x * K_INV) >>> 14, clamped to [0, 2^(W-1)-1].
// Only built when GAIN_COMP_EN is defined.
`ifdef GAIN_COMP_EN
module cordic_gain_mult
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [INT_W-1:0]      x,
  output logic        [DATA_WIDTH-1:0] mag
);

  localparam int PW = INT_W + 16;
  localparam logic signed [PW-1:0] MAG_MAX = PW'((2 ** (DATA_WIDTH - 1)) - 1);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;

  always_comb begin
    prod   = PW'(x) * PW'($signed(K_INV));
    scaled = prod >>> K_INV_FRAC;
    if (scaled < 0) begin
      mag = '0;
    end else if (scaled > MAG_MAX) begin
      mag = MAG_MAX[DATA_WIDTH-1:0];
    end else begin
      mag = scaled[DATA_WIDTH-1:0];
    end
  end

endmodule
`endif

// File: rtl/cordic_vector_core.sv
// Iterative CORDIC vectoring core: magnitude (Q2.14) and atan2 (Q3.13) of a Q2.14 vector.
// Define GAIN_COMP_EN to add a COMP cycle that removes the CORDIC gain from mag.
module cordic_vector_core
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [DATA_WIDTH-1:0] q,
  output logic        [ADDR_WIDTH-1:0] addr,
  output logic                         busy,
  output logic                         done,
  output logic        [DATA_WIDTH-1:0] mag,
  output logic signed [DATA_WIDTH-1:0] ang,
  output state_e                       dbg_state
);

  // Handshake: en with x_in/y_in is taken only while busy is low; done pulses one
  // cycle with mag/ang valid, and those outputs hold until the next done.
  localparam logic        [ADDR_WIDTH-1:0] LAST_N    = ADDR_WIDTH'(DATA_WIDTH - 2);
  localparam logic signed [INT_W-1:0]      HALF_PI_Z = INT_W'(HALF_PI_Q14);
  localparam logic signed [INT_W-1:0]      OUT_MAX   = INT_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [INT_W-1:0]      OUT_MIN   = INT_W'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic signed [INT_W-1:0]      ONE_Z     = INT_W'(1);

  state_e                         state_q, state_d;
  logic        [ADDR_WIDTH-1:0]   n_q, n_d;
  logic signed [INT_W-1:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic                           zero_q, zero_d;
  logic        [DATA_WIDTH-1:0]   mag_q, mag_d;
  logic signed [DATA_WIDTH-1:0]   ang_q, ang_d;

  logic signed [INT_W-1:0]        x_ext, y_ext, q_ext;
  logic signed [INT_W-1:0]        x_sh, y_sh, x_it, y_it, z_it;

  // z carries Q2.14 radians; halving with +1 gives round-half-up into Q3.13.
  function automatic logic signed [DATA_WIDTH-1:0] round_ang(input logic signed [INT_W-1:0] z);
    logic signed [INT_W-1:0] r;
    r = (z + ONE_Z) >>> 1;
    if (r > OUT_MAX) begin
      return OUT_MAX[DATA_WIDTH-1:0];
    end else if (r < OUT_MIN) begin
      return OUT_MIN[DATA_WIDTH-1:0];
    end else begin
      return r[DATA_WIDTH-1:0];
    end
  endfunction

`ifdef GAIN_COMP_EN
  logic [DATA_WIDTH-1:0] gain_mag;

  cordic_gain_mult #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_gain (
    .x  (x_q),
    .mag(gain_mag)
  );
`else
  function automatic logic [DATA_WIDTH-1:0] sat_mag(input logic signed [INT_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > OUT_MAX) begin
      return OUT_MAX[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    ang_d   = ang_q;

    x_ext = INT_W'(x_in);
    y_ext = INT_W'(y_in);
    q_ext = INT_W'(q);
    x_sh  = x_q >>> n_q;
    y_sh  = y_q >>> n_q;
    if (y_q[INT_W-1]) begin
      x_it = x_q - y_sh;
      y_it = y_q + x_sh;
      z_it = z_q - q_ext;
    end else begin
      x_it = x_q + y_sh;
      y_it = y_q - x_sh;
      z_it = z_q + q_ext;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ITER;
          n_d     = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          // Left half-plane is folded into the right by a +/-90 degree pre-rotation.
          if (x_in[DATA_WIDTH-1] && !y_in[DATA_WIDTH-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = HALF_PI_Z;
          end else if (x_in[DATA_WIDTH-1]) begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -HALF_PI_Z;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
        end
      end
      ST_ITER: begin
        x_d = x_it;
        y_d = y_it;
        z_d = z_it;
        n_d = n_q + 1'b1;
        if (n_q == LAST_N) begin
          n_d = '0;
`ifdef GAIN_COMP_EN
          state_d = ST_COMP;
`else
          state_d = ST_DONE;
          mag_d   = sat_mag(x_it);
          ang_d   = zero_q ? '0 : round_ang(z_it);
`endif
        end
      end
`ifdef GAIN_COMP_EN
      ST_COMP: begin
        state_d = ST_DONE;
        mag_d   = gain_mag;
        ang_d   = zero_q ? '0 : round_ang(z_q);
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign addr      = (state_q == ST_ITER) ? n_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mag       = mag_q;
  assign ang       = ang_q;
  assign dbg_state = state_q;

endmodule

// File: doc/cordic_vector_core.md
CORDIC_VECTOR_CORE -- requirements
Module: cordic_vector_core

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the input/output sample width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the atan ROM address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 en  input  1  SHALL request a conversion; sampled only in IDLE.
REQ-006 x_in, y_in  input  DATA_WIDTH signed  SHALL carry the Q2.14 vector; sampled with en.
REQ-007 q  input  DATA_WIDTH signed  SHALL carry atan(2^-addr) in Q2.14 radians from a combinational ROM, valid in the same cycle.
REQ-008 addr  output  ADDR_WIDTH  SHALL equal iteration index n in ITER, else 0.
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when results are valid.
REQ-011 mag  output  DATA_WIDTH unsigned  SHALL carry the vector magnitude in Q2.14.
REQ-012 ang  output  DATA_WIDTH signed  SHALL carry atan2(y_in, x_in) in Q3.13 radians (pi = 0x6488).

Function
REQ-013 FSM states SHALL be IDLE, ITER, COMP (macro only), DONE; DONE -> IDLE unconditionally.
REQ-014 IDLE with en=1 SHALL load 20-bit signed x/y/z registers, clear n, go to ITER; en while busy SHALL be ignored.
REQ-015 Load pre-rotation: x_in<0 & y_in>=0 -> (x,y,z)=(y_in,-x_in,+0x6488 Q2.14); x_in<0 & y_in<0 -> (-y_in,x_in,-0x6488); otherwise (x_in,y_in,0).
REQ-016 ITER, y>=0: x+=y>>>n, y-=x>>>n, z+=q; y<0: x-=y>>>n, y+=x>>>n, z-=q; arithmetic shifts, simultaneous update.
REQ-017 ITER SHALL run n=0..DATA_WIDTH-2 (15 iterations), then go to COMP or DONE.
REQ-018 ang SHALL be z>>>1 with round-half-up, saturated to DATA_WIDTH signed.
REQ-019 mag SHALL be saturated to 0x7FFF on overflow, never wrap.
REQ-020 mag/ang SHALL be registered on entry to DONE and held until the next completion.
REQ-021 done SHALL assert 16 cycles after the edge sampling en (15 without macro); en in the cycle after done SHALL start a new conversion.
REQ-022 Input (0,0) SHALL yield mag=0, ang=0; -32768 inputs SHALL not overflow internally.

Reset
REQ-023 rst SHALL force IDLE, n=0, x/y/z=0, mag=0, ang=0, done=0, busy=0, addr=0 on the next edge.
REQ-024 rst mid-conversion SHALL abort without a done pulse; rst has priority over en.

Configuration
REQ-025 With GAIN_COMP_EN defined, COMP SHALL compute mag=(x*0x26DD)>>>14 in one cycle (1/K compensation).
REQ-026 Without GAIN_COMP_EN, COMP SHALL not exist and mag SHALL be raw x (gain ~1.6468), saturated.

Structure
REQ-027 Package cordic_pkg SHALL hold the state enum, K_INV=0x26DD, HALF_PI_Q14=0x6488, internal width 20.
REQ-028 Gain multiply-and-saturate SHALL be sub-module cordic_gain_mult, instantiated only under GAIN_COMP_EN.
REQ-029 The atan ROM SHALL remain external, shared with the rotation core.

Verification
REQ-030 (0x4000,0) -> mag 0x4000 +/-4 LSB, ang 0x0000 +/-4, done at cycle 16.
REQ-031 (0,0x4000) -> ang 0x3244 +/-4; (-0x4000,0) -> ang 0x6488 +/-4, mag 0x4000 +/-4.
REQ-032 (0x2000,-0x2000) -> ang 0xE6DE +/-4, mag 0x2D41 +/-4.
REQ-033 Macro off, (0x4000,0) -> mag 0x6965 +/-8, done at cycle 15.
REQ-034 rst at ITER n=5 -> no done, mag=ang=0, busy=0 next cycle; en held during busy -> single done only.
REQ-035 Back-to-back: en the cycle after done -> second result correct, first held until then.
